mult_rr_scheduler: RTL
======================

Name: mult_rr_scheduler

Overview:
- Round-robin scheduler that shares one repeated-addition multiplier (valid/ready input side, valid_out result pulse) between NUM_REQ requesters.
- Accepts one operand pair at a time and issues it to the multiplier.
- Waits for the result, then returns it tagged with the requester index.
- Has a watchdog so a hung multiplier cannot deadlock requesters.
- Sits between client blocks and the single multiplier instance.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 4, operand width; product is 2*WIDTH
TIMEOUT, 64, max cycles in WAIT before error return (>=2)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester operand valid
req_a  input  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand B, same packing
req_ready  output  NUM_REQ  one-hot accept, combinational in IDLE
m_valid_in  output  1  operand valid to multiplier
m_ready_out  input  1  multiplier ready
m_a  output  WIDTH  operand A to multiplier
m_b  output  WIDTH  operand B to multiplier
m_mult_out  input  2*WIDTH  multiplier product
m_valid_out  input  1  multiplier result pulse
rsp_valid  output  1  one-cycle result pulse
rsp_id  output  $clog2(NUM_REQ)  requester index of response
rsp_data  output  2*WIDTH  product (0 on error)
rsp_err  output  1  high with rsp_valid if timeout occurred

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, ptr=0, wdog=0.
  - rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0.
  - m_a=0, m_b=0, latched id=0.
  - Outputs derived combinationally from state: m_valid_in=0, req_ready=0.
  - Reset mid-operation abandons the in-flight op with no response.
  - A late m_valid_out after reset is ignored (arrives in IDLE).
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 combinationally; all other bits 0; req_ready=0 if no valid.
  - On the transfer cycle: latch m_a=req_a[g], m_b=req_b[g], id=g; next state ISSUE.
- ISSUE:
  - m_valid_in=1, m_a/m_b held stable.
  - When m_valid_in && m_ready_out at posedge: next state WAIT, wdog=0.
  - Stays in ISSUE indefinitely while m_ready_out=0; the watchdog does not run here.
- WAIT:
  - m_valid_in=0; wdog increments each cycle.
  - If m_valid_out=1 at posedge: register rsp_valid=1, rsp_data=m_mult_out, rsp_id=id, rsp_err=0.
  - Else if wdog==TIMEOUT-1: register rsp_valid=1, rsp_data=0, rsp_id=id, rsp_err=1.
  - Either event: ptr=(id+1) mod NUM_REQ, next state IDLE.
  - m_valid_out takes priority over timeout in the same cycle.
- m_valid_out seen in IDLE or ISSUE is dropped.
- rsp_valid/rsp_err are one-cycle pulses, cleared the next cycle. There is no response backpressure.
- Latency:
  - Accept cycle, then >=1 ISSUE cycle, then WAIT.
  - rsp_valid rises the cycle after m_valid_out.
  - Minimum accept-to-rsp_valid = 3 cycles plus multiplier latency.
  - A new grant can occur in the same cycle rsp_valid is high.
- Requester rule: hold req_valid, req_a, req_b stable until req_ready. The scheduler does not check this.
- No combinational path from m_* inputs to req_ready.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... and no requester waits more than NUM_REQ-1 ops.

Test Plan:
- Single request: req_valid=0001, a=5, b=2; multiplier ready → req_ready=0001 for 1 cycle; m_a=5, m_b=2; rsp_valid pulse with rsp_id=0, rsp_data=8'h0A, rsp_err=0.
- Contention: req_valid=0110 from reset, id1 a=2 b=F, id2 a=3 b=3 → id1 served first (rsp_data=8'h1E), then id2 (rsp_data=8'h09), ptr=3 after.
- Fairness: all four valid continuously for 8 ops → rsp_id sequence 0,1,2,3,0,1,2,3, every rsp_data correct.
- Multiplier stall: hold m_ready_out=0 for 10 cycles in ISSUE → m_valid_in stays 1, m_a/m_b stable, no timeout; completes normally after release.
- Timeout: TIMEOUT=8, never assert m_valid_out → after 8 WAIT cycles rsp_valid=1, rsp_err=1, rsp_data=0; next grant proceeds.
- Reset mid-op: assert rst in WAIT, then deliver m_valid_out 2 cycles later → no rsp_valid; outputs at reset values; ptr=0 so id0 wins next.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// Round-robin front end for one shared repeated-addition multiplier: grants one
// requester at a time, issues its operands, and returns the tagged product or a timeout error.
module mult_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       m_valid_in,
    input  logic                       m_ready_out,
    output logic [WIDTH-1:0]           m_a,
    output logic [WIDTH-1:0]           m_b,
    input  logic [2*WIDTH-1:0]         m_mult_out,
    input  logic                       m_valid_out,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]         rsp_data,
    output logic                       rsp_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id;
    logic [WDW-1:0]   wdog;

    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   next_ptr;
    logic             wdog_expired;

    // Rotating priority search starting at ptr; depends only on req_valid and
    // registered state, so nothing on the multiplier side reaches req_ready.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_found)
            req_ready[grant_id] = 1'b1;
    end

    assign m_valid_in   = (state == S_ISSUE);
    assign next_ptr     = (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    assign wdog_expired = (wdog == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            id        <= '0;
            wdog      <= '0;
            m_a       <= '0;
            m_b       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        m_a   <= req_a[grant_id*WIDTH +: WIDTH];
                        m_b   <= req_b[grant_id*WIDTH +: WIDTH];
                        id    <= grant_id;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_ready_out) begin
                        wdog  <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wdog <= wdog + 1'b1;
                    // A real result wins over an expiring watchdog in the same cycle.
                    if (m_valid_out) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= m_mult_out;
                        rsp_id    <= id;
                        ptr       <= next_ptr;
                        state     <= S_IDLE;
                    end else if (wdog_expired) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_id    <= id;
                        ptr       <= next_ptr;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
